// File: rtl/charbuf_writer.sv
// charbuf_writer: cursor-tracking write controller for the 32x32 character buffer A port
module charbuf_writer #(
   parameter int          COLS       = 30,
   parameter int          ROWS       = 17,
   parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [7:0]  i_char,
   input  logic [7:0]  i_attr,
   output logic        o_ready,
   output logic [9:0]  o_ada,
   output logic [15:0] o_din,
   output logic        o_cea,
   output logic [4:0]  o_cur_x,
   output logic [4:0]  o_cur_y,
   output logic        o_busy
);
   localparam logic [7:0] C_BS = 8'h08;
   localparam logic [7:0] C_LF = 8'h0A;
   localparam logic [7:0] C_FF = 8'h0C;
   localparam logic [7:0] C_CR = 8'h0D;
   localparam logic [4:0] X_MAX = 5'(COLS - 1);
   localparam logic [4:0] Y_MAX = 5'(ROWS - 1);
   localparam logic [9:0] LAST_CELL = 10'h3FF;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [7:0]  attr_q, attr_d;
   logic [4:0]  cx_q, cx_d, cy_q, cy_d;
   logic        cea_q, cea_d;
   logic [9:0]  ada_q, ada_d;
   logic [15:0] din_q, din_d;
   logic        xfer;
   logic [4:0]  x_inc, y_inc;

   assign xfer  = i_valid & o_ready;
   assign x_inc = (cx_q == X_MAX) ? 5'd0 : cx_q + 5'd1;
   assign y_inc = (cy_q == Y_MAX) ? 5'd0 : cy_q + 5'd1;

   // state register; reset aborts any clear in progress
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // enter CLEAR on a form feed, leave once the cell 1023 write is on the port
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) state_d = (xfer && i_char == C_FF) ? CLEAR : IDLE;
      else                 state_d = (cnt_q == LAST_CELL) ? IDLE : CLEAR;
   end

   // handshake and status outputs
   always_comb begin
      o_ready = (state_q == IDLE) & ~i_rst;
      o_busy  = (state_q == CLEAR);
   end

   // cursor, sweep counter and write-port next state
   always_comb begin
      cx_d   = cx_q;
      cy_d   = cy_q;
      cnt_d  = cnt_q;
      attr_d = attr_q;
      cea_d  = 1'b0;
      ada_d  = ada_q;
      din_d  = din_q;
      if (state_q == CLEAR) begin
         if (cnt_q != LAST_CELL) begin
            cea_d = 1'b1;
            cnt_d = cnt_q + 10'd1;
            ada_d = cnt_q + 10'd1;
            din_d = {attr_q, BLANK_CHAR};
         end
      end else if (xfer) begin
         case (i_char)
            C_CR: cx_d = 5'd0;
            C_LF: cy_d = y_inc;
            C_BS: begin
               if (cx_q != 5'd0) begin
                  cx_d  = cx_q - 5'd1;
                  cea_d = 1'b1;
               end else if (cy_q != 5'd0) begin
                  cx_d  = X_MAX;
                  cy_d  = cy_q - 5'd1;
                  cea_d = 1'b1;
               end
               ada_d = cea_d ? {cy_d, cx_d} : ada_q;
               din_d = cea_d ? {i_attr, BLANK_CHAR} : din_q;
            end
            C_FF: begin
               attr_d = i_attr;
               cx_d   = 5'd0;
               cy_d   = 5'd0;
               cnt_d  = 10'd0;
               cea_d  = 1'b1;
               ada_d  = 10'd0;
               din_d  = {i_attr, BLANK_CHAR};
            end
            default: begin
               cea_d = 1'b1;
               ada_d = {cy_q, cx_q};
               din_d = {i_attr, i_char};
               cx_d  = x_inc;
               cy_d  = (cx_q == X_MAX) ? y_inc : cy_q;
            end
         endcase
      end
   end

   // datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cx_q   <= 5'd0;
         cy_q   <= 5'd0;
         cnt_q  <= 10'd0;
         attr_q <= 8'd0;
         cea_q  <= 1'b0;
         ada_q  <= 10'd0;
         din_q  <= 16'd0;
      end else begin
         cx_q   <= cx_d;
         cy_q   <= cy_d;
         cnt_q  <= cnt_d;
         attr_q <= attr_d;
         cea_q  <= cea_d;
         ada_q  <= ada_d;
         din_q  <= din_d;
      end
   end

   assign o_cea   = cea_q;
   assign o_ada   = ada_q;
   assign o_din   = din_q;
   assign o_cur_x = cx_q;
   assign o_cur_y = cy_q;
endmodule

// File: tb/tb_charbuf_writer.sv
// tb_charbuf_writer: directed stimulus checked against a linear-cursor behavioural model
module tb_charbuf_writer;
   localparam int COLS = 30;
   localparam int ROWS = 17;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [7:0]  ch = 8'h00;
   logic [7:0]  at = 8'h00;
   logic        o_ready, o_cea, o_busy;
   logic [9:0]  o_ada;
   logic [15:0] o_din;
   logic [4:0]  o_cur_x, o_cur_y;

   int n_tests = 0;
   int n_fail = 0;

   charbuf_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK_CHAR(8'h20)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_char(ch), .i_attr(at),
      .o_ready(o_ready), .o_ada(o_ada), .o_din(o_din), .o_cea(o_cea),
      .o_cur_x(o_cur_x), .o_cur_y(o_cur_y), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_tests++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
      end
   endtask

   // model: cursor is a linear cell index over the visible area
   bit          m_on = 1'b0;
   bit          acc;
   int          m_x, m_y, m_left, p;
   logic [7:0]  m_attr;
   logic        e_cea, e_busy;
   logic [9:0]  e_ada;
   logic [15:0] e_din;

   always @(negedge clk) begin
      if (m_on) begin
         chk("cea", 32'(o_cea), 32'(e_cea));
         chk("ada", 32'(o_ada), 32'(e_ada));
         chk("din", 32'(o_din), 32'(e_din));
         chk("cur_x", 32'(o_cur_x), m_x);
         chk("cur_y", 32'(o_cur_y), m_y);
         chk("busy", 32'(o_busy), 32'(e_busy));
         chk("ready", 32'(o_ready), 32'(!e_busy && !rst));
      end
      if (rst) begin
         m_on = 1'b1; m_x = 0; m_y = 0; m_left = 0; m_attr = 8'h00;
         e_cea = 1'b0; e_busy = 1'b0; e_ada = 10'd0; e_din = 16'd0;
      end else if (m_on) begin
         acc = valid && !e_busy;
         e_cea = 1'b0;
         if (acc) begin
            if (ch == 8'h0D) m_x = 0;
            else if (ch == 8'h0A) m_y = (m_y + 1) % ROWS;
            else if (ch == 8'h0C) begin
               m_left = 1024; m_attr = at; m_x = 0; m_y = 0;
            end else if (ch == 8'h08) begin
               p = m_y * COLS + m_x;
               if (p > 0) begin
                  p = p - 1; m_x = p % COLS; m_y = p / COLS;
                  e_cea = 1'b1; e_ada = 10'(m_y * 32 + m_x); e_din = {at, 8'h20};
               end
            end else begin
               e_cea = 1'b1; e_ada = 10'(m_y * 32 + m_x); e_din = {at, ch};
               p = (m_y * COLS + m_x + 1) % (COLS * ROWS);
               m_x = p % COLS; m_y = p / COLS;
            end
         end
         if (m_left > 0) begin
            e_cea = 1'b1; e_ada = 10'(1024 - m_left); e_din = {m_attr, 8'h20};
            m_left--; e_busy = 1'b1;
         end else e_busy = 1'b0;
      end
   end

   // present a character and return once it has been accepted; valid stays high
   task automatic send(input logic [7:0] c, input logic [7:0] a, output int waits);
      logic r;
      waits = 0;
      ch = c; at = a; valid = 1'b1;
      forever begin
         @(negedge clk); r = o_ready;
         @(posedge clk); #1;
         if (r) break;
         waits++;
         if (waits > 2000) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: char %0h not accepted after %0d cycles", c, waits);
            break;
         end
      end
   endtask

   task automatic put(input logic [7:0] c, input logic [7:0] a);
      int w;
      send(c, a, w);
      valid = 1'b0;
   endtask

   task automatic do_reset();
      valid = 1'b0; rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int w;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cea", 32'(o_cea), 0);
      chk("rst_ada", 32'(o_ada), 0);
      chk("rst_din", 32'(o_din), 0);
      chk("rst_cur", 32'({o_cur_y, o_cur_x}), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_ready_low", 32'(o_ready), 0);
      rst = 1'b0;
      #1 chk("rst_ready_high", 32'(o_ready), 1);
      // 1: single printable
      put(8'h41, 8'h1F);
      chk("a_cea", 32'(o_cea), 1);
      chk("a_ada", 32'(o_ada), 32'h000);
      chk("a_din", 32'(o_din), 32'h1F41);
      chk("a_cur", 32'({o_cur_y, o_cur_x}), {5'd0, 5'd1});
      // 2: row wrap across a full line, streamed
      do_reset();
      for (int i = 0; i < 30; i++) begin
         send(8'h30 + 8'(i), 8'h07, w);
         chk("row_ada", 32'(o_ada), i);
         chk("row_wait", w, 0);
      end
      chk("row_cur", 32'({o_cur_y, o_cur_x}), {5'd1, 5'd0});
      send(8'h58, 8'h07, w);
      valid = 1'b0;
      chk("row31_ada", 32'(o_ada), 32'h020);
      // 3: bottom-right wrap and LF wrap
      do_reset();
      repeat (16) put(8'h0A, 8'h00);
      repeat (29) put(8'h2E, 8'h02);
      chk("br_cur", 32'({o_cur_y, o_cur_x}), {5'd16, 5'd29});
      put(8'h5A, 8'h03);
      chk("br_ada", 32'(o_ada), 32'h21D);
      chk("br_din", 32'(o_din), 32'h035A);
      chk("br_cur0", 32'({o_cur_y, o_cur_x}), 0);
      repeat (16) put(8'h0A, 8'h00);
      put(8'h0A, 8'h00);
      chk("lf_wrap_y", 32'(o_cur_y), 0);
      chk("lf_nowrite", 32'(o_cea), 0);
      // 4: backspace across a line and at home
      do_reset();
      put(8'h0A, 8'h00); put(8'h0A, 8'h00);
      put(8'h08, 8'h07);
      chk("bs_cea", 32'(o_cea), 1);
      chk("bs_ada", 32'(o_ada), 32'h03D);
      chk("bs_din", 32'(o_din), 32'h0720);
      chk("bs_cur", 32'({o_cur_y, o_cur_x}), {5'd1, 5'd29});
      do_reset();
      put(8'h08, 8'h07);
      chk("bs_home_cea", 32'(o_cea), 0);
      chk("bs_home_cur", 32'({o_cur_y, o_cur_x}), 0);
      // 5: full clear with a held character behind it
      put(8'h41, 8'h01); put(8'h42, 8'h01);
      send(8'h0C, 8'h40, w);
      chk("ff_first_ada", 32'(o_ada), 0);
      chk("ff_first_din", 32'(o_din), 32'h4020);
      chk("ff_busy", 32'(o_busy), 1);
      send(8'h51, 8'h07, w);
      valid = 1'b0;
      chk("ff_wait", w, 1024);
      chk("ff_after_ada", 32'(o_ada), 0);
      chk("ff_after_din", 32'(o_din), 32'h0751);
      chk("ff_after_cur", 32'({o_cur_y, o_cur_x}), {5'd0, 5'd1});
      // 6: reset mid-clear, then a continuous stream
      put(8'h0C, 8'h40);
      repeat (500) begin @(posedge clk); #1; end
      chk("clr500_ada", 32'(o_ada), 500);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_cea", 32'(o_cea), 0);
      chk("abort_busy", 32'(o_busy), 0);
      chk("abort_cur", 32'({o_cur_y, o_cur_x}), 0);
      rst = 1'b0;
      #1 chk("abort_ready", 32'(o_ready), 1);
      send(8'h42, 8'h0E, w);
      chk("s_b_ada", 32'(o_ada), 0);
      chk("s_b_wait", w, 0);
      send(8'h43, 8'h0E, w);
      chk("s_c_ada", 32'(o_ada), 1);
      chk("s_c_wait", w, 0);
      send(8'h0D, 8'h0E, w);
      chk("s_cr_cea", 32'(o_cea), 0);
      chk("s_cr_x", 32'(o_cur_x), 0);
      send(8'h44, 8'h0E, w);
      valid = 1'b0;
      chk("s_d_ada", 32'(o_ada), 0);
      chk("s_d_din", 32'(o_din), 32'h0E44);
      chk("s_d_wait", w, 0);
      repeat (3) @(posedge clk);
      #1 $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
